// File: rtl/state_sequencer_pkg.sv
// state_sequencer_pkg: shared state indices, class indices and default per-class cycle lengths
package state_sequencer_pkg;
    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int CLASS_ALU  = 0;
    localparam int CLASS_LD   = 1;
    localparam int CLASS_ST   = 2;
    localparam int CLASS_PUSH = 3;
    localparam int CLASS_POP  = 4;
    localparam int CLASS_JUMP = 5;
    localparam int CLASS_BE   = 6;
    localparam logic [27:0] DEF_CLASS_LEN = {4'd4, 4'd3, 4'd5, 4'd5, 4'd4, 4'd5, 4'd4};
endpackage

// File: rtl/state_sequencer_class_encoder.sv
// class_encoder: one-hot class vector to index plus exactly-one-hot valid flag
module class_encoder #(
    parameter int N  = 7,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (onehot[i]) idx = idx | IW'(i);
    end
    assign valid = (onehot != '0) && ((onehot & (onehot - 1'b1)) == '0);
endmodule

// File: rtl/state_sequencer.sv
// state_sequencer: FETCH/DECODE/EXECUTE step sequencer with per-class lengths, stall, flush, trap and retire count
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int                         STATE_W   = 3,
    parameter int                         N_CLASSES = 7,
    parameter int                         LEN_W     = 4,
    parameter logic [N_CLASSES*LEN_W-1:0] CLASS_LEN = DEF_CLASS_LEN,
    parameter int                         CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [N_CLASSES-1:0]         class_vec,
    output logic [STATE_W-1:0]           state,
    output logic [2**STATE_W-1:0]        state_onehot,
    output logic [$clog2(N_CLASSES)-1:0] cur_class,
    output logic                         instr_done,
    output logic                         illegal,
    output logic [CNT_W-1:0]             retired_cnt
);
    localparam int CW = $clog2(N_CLASSES);
    localparam logic [STATE_W-1:0] FETCH  = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] DECODE = STATE_W'(S_DECODE);
    localparam logic [STATE_W-1:0] EXEC0  = STATE_W'(2);
    for (genvar i = 0; i < N_CLASSES; i++) begin : g_chk
        if (CLASS_LEN[i*LEN_W +: LEN_W] < 2 || CLASS_LEN[i*LEN_W +: LEN_W] > 2**STATE_W) begin : g_bad
            $error("CLASS_LEN entry %0d out of range 2..2**STATE_W", i);
        end
    end
    if (LEN_W < STATE_W + 1) begin : g_lenw
        $error("LEN_W must be at least STATE_W+1");
    end
    logic [CW-1:0]      dec_idx, nxt_class;
    logic               dec_valid;
    logic [LEN_W-1:0]   dec_len, cur_len;
    logic [STATE_W-1:0] nxt;
    class_encoder #(.N(N_CLASSES), .IW(CW)) u_enc (
        .onehot(class_vec),
        .idx   (dec_idx),
        .valid (dec_valid)
    );
    assign dec_len      = CLASS_LEN[dec_idx*LEN_W +: LEN_W];
    assign cur_len      = CLASS_LEN[cur_class*LEN_W +: LEN_W];
    assign state_onehot = {{(2**STATE_W-1){1'b0}}, 1'b1} << state;
    always_comb begin
        nxt        = state;
        nxt_class  = cur_class;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (flush) begin
            nxt = FETCH;
        end else if (!stall) begin
            if (state == FETCH) begin
                nxt = DECODE;
            end else if (state == DECODE) begin
                nxt_class  = dec_valid ? dec_idx : cur_class;
                illegal    = !dec_valid;
                instr_done = dec_valid && dec_len == LEN_W'(2);
                nxt        = (dec_valid && !instr_done) ? EXEC0 : FETCH;
            end else begin
                instr_done = LEN_W'(state) == cur_len - 1'b1;
                nxt        = instr_done ? FETCH : state + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            cur_class   <= '0;
            retired_cnt <= '0;
        end else begin
            state     <= nxt;
            cur_class <= nxt_class;
            if (instr_done) retired_cnt <= retired_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_state_sequencer.sv
// tb_state_sequencer: directed stimulus against a cycle-position model of the sequencer
module tb_state_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [6:0]  class_vec = '0;
    logic [2:0]  state, cur_class;
    logic [7:0]  state_onehot;
    logic        instr_done, illegal;
    logic [15:0] retired_cnt;
    int checks = 0, errors = 0;
    int lens [7] = '{4, 5, 4, 5, 5, 3, 4};
    int m_pos = 0, m_cls = 0;
    logic [15:0] m_cnt = '0;

    always #5 clk = ~clk;

    state_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .class_vec(class_vec),
        .state(state), .state_onehot(state_onehot), .cur_class(cur_class),
        .instr_done(instr_done), .illegal(illegal), .retired_cnt(retired_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [6:0] v);
        for (int i = 0; i < 7; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic exp_done();
        int k = idx_of(class_vec);
        if (flush || stall) return 1'b0;
        if (m_pos == 1) return $countones(class_vec) == 1 && lens[k] == 2;
        return m_pos >= 2 && m_pos == lens[m_cls] - 1;
    endfunction

    function automatic logic exp_illegal();
        return !flush && !stall && m_pos == 1 && $countones(class_vec) != 1;
    endfunction

    always @(negedge rst_n) begin
        m_pos = 0;
        m_cls = 0;
        m_cnt = '0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            logic d;
            d = exp_done();
            if (flush) m_pos = 0;
            else if (!stall) begin
                if (m_pos == 1 && $countones(class_vec) == 1) m_cls = idx_of(class_vec);
                if (d || (m_pos == 1 && $countones(class_vec) != 1)) m_pos = 0;
                else if (m_pos == 1) m_pos = 2;
                else m_pos = m_pos + 1;
                if (d) m_cnt = m_cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_state", 32'(state), 32'(m_pos));
            chk("m_onehot", 32'(state_onehot), 32'(8'd1 << m_pos));
            chk("m_cur_class", 32'(cur_class), 32'(m_cls));
            chk("m_instr_done", 32'(instr_done), 32'(exp_done()));
            chk("m_illegal", 32'(illegal), 32'(exp_illegal()));
            chk("m_retired_cnt", 32'(retired_cnt), 32'(m_cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        chk("rst_state", 32'(state), 0);
        chk("rst_onehot", 32'(state_onehot), 1);
        chk("rst_cur_class", 32'(cur_class), 0);
        chk("rst_done", 32'(instr_done), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_cnt", 32'(retired_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        class_vec = 7'b0000001;
        step(3);
        @(negedge clk);
        chk("t1_state3", 32'(state), 3);
        chk("t1_done", 32'(instr_done), 1);
        step(1);
        chk("t1_cnt1", 32'(retired_cnt), 1);
        step(4);
        chk("t1_cnt2", 32'(retired_cnt), 2);
        chk("t1_state0", 32'(state), 0);
        reset_pulse();
        for (int c = 0; c < 7; c++) begin
            int hl;
            hl = (c == 1 || c == 3 || c == 4) ? 5 : (c == 5) ? 3 : 4;
            class_vec = 7'(1 << c);
            step(hl - 1);
            chk("t2_last_state", 32'(state), 32'(hl - 1));
            chk("t2_last_done", 32'(instr_done), 1);
            step(1);
            chk("t2_back_fetch", 32'(state), 0);
            chk("t2_class", 32'(cur_class), 32'(c));
        end
        chk("t2_cnt7", 32'(retired_cnt), 7);
        class_vec = 7'b0000010;
        step(2);
        class_vec = 7'b0100000;
        step(2);
        chk("t3_state4", 32'(state), 4);
        chk("t3_class_ld", 32'(cur_class), 1);
        chk("t3_done", 32'(instr_done), 1);
        step(1);
        chk("t3_cnt8", 32'(retired_cnt), 8);
        foreach (lens[i]) begin
            if (i < 2) begin
                class_vec = (i == 0) ? 7'b0000000 : 7'b0000011;
                step(1);
                chk("t4_illegal", 32'(illegal), 1);
                step(1);
                chk("t4_state0", 32'(state), 0);
                chk("t4_cnt", 32'(retired_cnt), 8);
                chk("t4_class", 32'(cur_class), 1);
            end
        end
        class_vec = 7'b0001000;
        step(3);
        stall = 1'b1;
        step(3);
        chk("t5_hold3", 32'(state), 3);
        chk("t5_nodone", 32'(instr_done), 0);
        stall = 1'b0;
        step(1);
        chk("t5_state4", 32'(state), 4);
        step(1);
        chk("t5_retired", 32'(retired_cnt), 9);
        step(2);
        chk("t5_state2", 32'(state), 2);
        stall = 1'b1;
        flush = 1'b1;
        step(1);
        chk("t5_flush0", 32'(state), 0);
        chk("t5_flush_class", 32'(cur_class), 3);
        stall = 1'b0;
        flush = 1'b0;
        class_vec = 7'b0010000;
        step(3);
        chk("t6_state3", 32'(state), 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_state", 32'(state), 0);
        chk("t6_async_cnt", 32'(retired_cnt), 0);
        rst_n = 1'b1;
        class_vec = 7'b0000001;
        step(1);
        force dut.retired_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.retired_cnt;
        @(negedge clk);
        chk("t6_preload", 32'(retired_cnt), 32'hFFFF);
        step(3);
        chk("t6_wrap", 32'(retired_cnt), 0);
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
